// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if : byte-stream input and instruction-memory write bus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

interface imem_loader_if;
   logic                  rx_valid;
   logic [7:0]            rx_byte;
   logic                  rx_ready;
   logic                  imem_we;
   logic [`WORD-1:0]      imem_addr;
   logic [`INSTR_LEN-1:0] imem_wdata;

   modport master (
      input  rx_valid, rx_byte,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output rx_valid, rx_byte,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader : loads a length-prefixed, XOR-checksummed program into imem
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module imem_loader #(
   parameter logic [`WORD-1:0] BASE_ADDR = '0,
   parameter int               MAX_WORDS = 256
) (
   input  wire logic     clk,
   input  wire logic     reset,
   input  wire logic     start,
   imem_loader_if.master bus,
   output logic          cpu_hold,
   output logic          done,
   output logic          error
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_LEN_LO = 3'd1;
   localparam logic [2:0] c_LEN_HI = 3'd2;
   localparam logic [2:0] c_DATA   = 3'd3;
   localparam logic [2:0] c_CSUM   = 3'd4;
   localparam logic [2:0] c_DONE   = 3'd5;
   localparam logic [2:0] c_ERR    = 3'd6;

   logic [2:0]            r_state;
   logic [15:0]           r_len;
   logic [15:0]           r_word_cnt;
   logic [1:0]            r_byte_idx;
   logic [23:0]           r_word;
   logic [7:0]            r_csum;
   logic [`WORD-1:0]      r_next_addr;
   logic [`WORD-1:0]      r_addr;
   logic [`INSTR_LEN-1:0] r_wdata;
   logic                  r_we;
   logic                  r_done;
   logic                  r_error;

   logic                  w_ready;
   logic                  w_xfer;
   logic                  w_begin;
   logic [15:0]           w_len;
   logic                  w_too_long;
   logic                  w_last_word;

   assign w_ready     = (r_state == c_LEN_LO) || (r_state == c_LEN_HI) ||
                        (r_state == c_DATA)   || (r_state == c_CSUM);
   assign w_xfer      = bus.rx_valid && w_ready;
   // start is honoured only while no load is in flight
   assign w_begin     = start && ((r_state == c_IDLE) || (r_state == c_DONE) ||
                                  (r_state == c_ERR));
   assign w_len       = {bus.rx_byte, r_len[7:0]};
   assign w_too_long  = {1'b0, w_len} > 17'(MAX_WORDS);
   assign w_last_word = (r_word_cnt == (r_len - 16'd1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= c_IDLE;
         r_len       <= '0;
         r_word_cnt  <= '0;
         r_byte_idx  <= '0;
         r_word      <= '0;
         r_csum      <= '0;
         r_next_addr <= BASE_ADDR;
         r_addr      <= BASE_ADDR;
         r_wdata     <= '0;
         r_we        <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (w_begin) begin
            r_state     <= c_LEN_LO;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_csum      <= '0;
            r_next_addr <= BASE_ADDR;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
         end else if (w_xfer) begin
            case (r_state)
               c_LEN_LO: begin
                  r_len[7:0] <= bus.rx_byte;
                  r_state    <= c_LEN_HI;
               end
               c_LEN_HI: begin
                  r_len <= w_len;
                  if (w_too_long) begin
                     r_state <= c_ERR;
                     r_error <= 1'b1;
                  end else if (w_len == 16'd0) begin
                     r_state <= c_CSUM;
                  end else begin
                     r_state <= c_DATA;
                  end
               end
               c_DATA: begin
                  r_csum     <= r_csum ^ bus.rx_byte;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  case (r_byte_idx)
                     2'd0: r_word[7:0]   <= bus.rx_byte;
                     2'd1: r_word[15:8]  <= bus.rx_byte;
                     2'd2: r_word[23:16] <= bus.rx_byte;
                     default: begin
                        // the write issues on the next cycle; the state may move on meanwhile
                        r_we        <= 1'b1;
                        r_addr      <= r_next_addr;
                        r_next_addr <= r_next_addr + `WORD'(4);
                        r_wdata     <= {bus.rx_byte, r_word};
                        r_word_cnt  <= r_word_cnt + 16'd1;
                        if (w_last_word) begin
                           r_state <= c_CSUM;
                        end
                     end
                  endcase
               end
               c_CSUM: begin
                  if (bus.rx_byte == r_csum) begin
                     r_state <= c_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= c_ERR;
                     r_error <= 1'b1;
                  end
               end
               default: r_state <= r_state;
            endcase
         end
      end
   end

   assign bus.rx_ready   = w_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign cpu_hold       = (r_state != c_DONE);
   assign done           = r_done;
   assign error          = r_error;

endmodule

`default_nettype wire
